dcache_ctrl: RTL and testbench

Data-side responder for the MemRead/MemWrite strobes that the control path produces for load and store instructions. It is a direct-mapped, write-through, no-write-allocate data cache that sits between the core's memory stage and the backing main memory. It serves load hits with zero added latency. On a load miss or any store, it raises Stall while it completes a word-wide handshake with main memory.

---
 rtl/dcache_ctrl.sv | 165 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
//   Direct-mapped, write-through, no-write-allocate data cache that answers
//   the core's MemRead/MemWrite strobes. Load hits return data in the same
//   cycle; load misses refill a whole line from main memory (ascending beat
//   order, starting at word 0), and stores are always written through as a
//   single beat.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   MemRead, MemWrite   load / store request (store wins if both are high)
//   addr, wdata         word-aligned byte address, store data
//   rdata               load data, valid when MemRead && !Stall
//   Stall               hold the pipeline and request inputs while high
//   mem_req, mem_we     memory beat valid, 1 = write beat
//   mem_addr, mem_wdata memory beat address / write data
//   mem_ready           beat accepted this cycle (ignored while mem_req=0)
//   mem_rdata           read beat data, valid with mem_ready
//
// state  | meaning
// IDLE   | accept requests; load hits are answered here
// REFILL | fetch BLOCK_WORDS words of the missing line, one per mem_ready
// WRITE  | single write-through beat held until mem_ready
// RESP   | one cycle: request completes with Stall=0
module dcache_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              Stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } state_t;

  state_t           r_state;
  logic [OFF_W-1:0] r_count;
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [31:0]      r_data [SETS*BLOCK_WORDS];

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [31:0]      w_word;
  logic             w_last_beat;
  logic [1:0]       w_unused_addr;

  assign w_off         = addr[OFF_W+1:2];
  assign w_idx         = addr[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag         = addr[ADDR_W-1:OFF_W+IDX_W+2];
  assign w_unused_addr = addr[1:0];

  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word      = r_data[{w_idx, w_off}];
  assign w_last_beat = (r_count == LAST_BEAT);

  // Control state; valid bits live here because they are the only part of
  // the arrays that reset touches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (MemWrite) begin
            r_state <= ST_WRITE;
          end else if (MemRead && !w_hit) begin
            r_state <= ST_REFILL;
            r_count <= '0;
          end
        end
        ST_REFILL: begin
          if (mem_ready) begin
            // count wraps back to 0 after the final beat
            r_count <= r_count + 1'b1;
            if (w_last_beat) begin
              r_valid[w_idx] <= 1'b1;
              r_state        <= ST_RESP;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ready) r_state <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_REFILL && mem_ready) begin
        r_data[{w_idx, r_count}] <= mem_rdata;
        if (w_last_beat) r_tag[w_idx] <= w_tag;
      end
      // no-write-allocate: a store miss leaves the line untouched
      if (r_state == ST_WRITE && mem_ready && w_hit) begin
        r_data[{w_idx, w_off}] <= wdata;
      end
    end
  end

  always_comb begin
    Stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rdata     = '0;
    case (r_state)
      ST_IDLE: begin
        if (MemWrite) begin
          Stall = 1'b1;
        end else if (MemRead) begin
          if (w_hit) rdata = w_word;
          else       Stall = 1'b1;
        end
      end
      ST_REFILL: begin
        Stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, r_count, 2'b00};
      end
      ST_WRITE: begin
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr[ADDR_W-1:2], 2'b00};
        mem_wdata = wdata;
      end
      ST_RESP: begin
        if (MemRead) rdata = w_word;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl
//   Directed bench for dcache_ctrl. A small main-memory model answers beats;
//   untouched words read back as 32'h5A000000 ^ address.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        Stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] beat_q [$];
  int          hold_cnt;

  always #5 clk = ~clk;

  dcache_ctrl #(.ADDR_W(32), .SETS(16), .BLOCK_WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return 32'h5A000000 ^ a;
  endfunction

  // One request from the core; memory delays every beat by wait_n cycles.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int wait_n,
                        output int stalls, output logic [31:0] rd_data);
    int  w = 0;
    int  n = 0;
    bit  done = 0;
    stalls   = 0;
    rd_data  = '0;
    hold_cnt = 0;
    beat_q.delete();
    @(negedge clk);
    MemRead  = rd;
    MemWrite = wr;
    addr     = a;
    wdata    = wd;
    while (!done && n < 60) begin
      #1;
      if (mem_req) begin
        if (mem_we && mem_addr == a && mem_wdata == wd) hold_cnt++;
        if (w >= wait_n) begin
          mem_ready = 1'b1;
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else        mem_rdata = mem_read(mem_addr);
          beat_q.push_back(mem_addr);
          w = 0;
        end else begin
          mem_ready = 1'b0;
          w++;
        end
      end else begin
        mem_ready = 1'b0;
      end
      #1;
      if (Stall) stalls++;
      else begin
        rd_data = rdata;
        done    = 1;
      end
      @(posedge clk);
      n++;
      if (!done) @(negedge clk);
    end
    if (!done) check("access_timeout", 32'd1, 32'd0);
    @(negedge clk);
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    mem_ready = 1'b0;
  endtask

  int          st;
  logic [31:0] rd;

  initial begin
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_stall", {31'd0, Stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);

    // cold miss, memory ready every cycle
    access(1'b1, 1'b0, 32'h40, 32'd0, 0, st, rd);
    check("miss40_stall", st, 32'd5);
    check("miss40_beats", beat_q.size(), 32'd4);
    check("miss40_beat0", beat_q[0], 32'h40);
    check("miss40_beat1", beat_q[1], 32'h44);
    check("miss40_beat3", beat_q[3], 32'h4C);
    check("miss40_rdata", rd, 32'h5A000040);

    access(1'b1, 1'b0, 32'h44, 32'd0, 0, st, rd);
    check("hit44_stall", st, 32'd0);
    check("hit44_beats", beat_q.size(), 32'd0);
    check("hit44_rdata", rd, 32'h5A000044);

    // store hit, memory waits 3 cycles before accepting
    access(1'b0, 1'b1, 32'h48, 32'hDEADBEEF, 3, st, rd);
    check("st48_stall", st, 32'd5);
    check("st48_beats", beat_q.size(), 32'd1);
    check("st48_addr", beat_q[0], 32'h48);
    check("st48_held", hold_cnt, 32'd4);
    access(1'b1, 1'b0, 32'h48, 32'd0, 0, st, rd);
    check("ld48_stall", st, 32'd0);
    check("ld48_rdata", rd, 32'hDEADBEEF);

    // store miss: no allocate
    access(1'b0, 1'b1, 32'h100, 32'h12345678, 0, st, rd);
    check("st100_stall", st, 32'd2);
    check("st100_beats", beat_q.size(), 32'd1);
    access(1'b1, 1'b0, 32'h100, 32'd0, 0, st, rd);
    check("ld100_stall", st, 32'd5);
    check("ld100_beats", beat_q.size(), 32'd4);
    check("ld100_beat0", beat_q[0], 32'h100);
    check("ld100_beat3", beat_q[3], 32'h10C);
    check("ld100_rdata", rd, 32'h12345678);

    // conflict on index 4
    access(1'b1, 1'b0, 32'h440, 32'd0, 0, st, rd);
    check("ld440_stall", st, 32'd5);
    check("ld440_rdata", rd, 32'h5A000440);
    access(1'b1, 1'b0, 32'h40, 32'd0, 1, st, rd);
    check("reld40_stall", st, 32'd9);
    check("reld40_rdata", rd, 32'h5A000040);
    access(1'b1, 1'b0, 32'h48, 32'd0, 0, st, rd);
    check("reld48_stall", st, 32'd0);
    check("reld48_rdata", rd, 32'hDEADBEEF);

    // reset after two refill beats of 0x40
    access(1'b1, 1'b0, 32'h440, 32'd0, 0, st, rd);
    check("evict_stall", st, 32'd5);
    @(negedge clk);
    MemRead = 1'b1; addr = 32'h40;
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      #1;
      mem_ready = 1'b1;
      mem_rdata = mem_read(mem_addr);
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1; MemRead = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    check("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
    check("rstmid_stall", {31'd0, Stall}, 32'd0);
    access(1'b1, 1'b0, 32'h40, 32'd0, 0, st, rd);
    check("rstmid_reld_stall", st, 32'd5);
    check("rstmid_reld_beats", beat_q.size(), 32'd4);
    check("rstmid_reld_rdata", rd, 32'h5A000040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
